// File: rtl/busint_arb.sv
// busint_arb: round-robin arbiter of NM masters onto one shared xbus with slave decode, timeout/NXM error and IRQ merge.
// Revision: 1.0
`default_nettype none

module busint_arb #(
  parameter int NM  = 2,
  parameter int NS  = 5,
  parameter int AW  = 22,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic [NM-1:0]      m_req,
  input  logic [NM-1:0]      m_write,
  input  logic [NM*AW-1:0]   m_addr,
  input  logic [NM*DW-1:0]   m_wdata,
  output logic [NM-1:0]      m_ack,
  output logic [NM-1:0]      m_err,
  output logic [DW-1:0]      m_rdata,
  output logic               load,
  output logic               bus_req,
  output logic               bus_write,
  output logic [AW-1:0]      bus_addr,
  output logic [DW-1:0]      bus_wdata,
  output logic [NM-1:0]      bus_grant,
  input  logic [NS-1:0]      s_decode,
  input  logic [NS-1:0]      s_ack,
  input  logic [NS*DW-1:0]   s_rdata,
  input  logic [NS-1:0]      s_irq,
  output logic               interrupt
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [NM-1:0] req_rot;
  logic [PW-1:0] off;
  logic [PW-1:0] pick;
  logic [NM-1:0] pick_onehot;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;
  logic          pick_write;
  logic [NS-1:0] hit;
  logic [DW-1:0] hit_data;
  logic          own_req;

  // Rotate requests so bit 0 is the master at ptr; the lowest set bit is the next owner.
  always_comb begin
    req_rot = NM'({m_req, m_req} >> ptr);
    off     = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (req_rot[i]) off = PW'(i);
    end
    pick = PW'((int'(ptr) + int'(off)) % NM);
  end

  always_comb begin
    pick_onehot = '0;
    pick_addr   = '0;
    pick_wdata  = '0;
    pick_write  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (PW'(i) == pick) begin
        pick_onehot[i] = 1'b1;
        pick_addr      = m_addr[i*AW +: AW];
        pick_wdata     = m_wdata[i*DW +: DW];
        pick_write     = m_write[i];
      end
    end
  end

  // Lowest-index slave that both decodes and acks supplies the read data.
  always_comb begin
    hit      = s_decode & s_ack;
    hit_data = '1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (hit[i]) hit_data = s_rdata[i*DW +: DW];
    end
  end

  assign own_req = |(m_req & bus_grant);

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      bus_grant <= '0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      m_ack     <= '0;
      m_err     <= '0;
      load      <= 1'b0;
      m_rdata   <= '1;
      interrupt <= 1'b0;
    end else begin
      interrupt <= |s_irq;
      case (state)
        IDLE: begin
          if (|m_req) begin
            bus_grant <= pick_onehot;
            bus_addr  <= pick_addr;
            bus_wdata <= pick_wdata;
            bus_write <= pick_write;
            bus_req   <= 1'b1;
            cnt       <= '0;
            ptr       <= PW'((int'(pick) + 1) % NM);
            state     <= REQ;
          end
        end
        REQ: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (!own_req) begin
            bus_req   <= 1'b0;
            bus_grant <= '0;
            state     <= IDLE;
          end else if (s_decode == '0) begin
            bus_req <= 1'b0;
            m_err   <= bus_grant;
            m_rdata <= '1;
            state   <= DONE;
          end else if (|hit) begin
            bus_req <= 1'b0;
            m_ack   <= bus_grant;
            m_rdata <= bus_write ? '1 : hit_data;
            load    <= !bus_write;
            state   <= DONE;
          end else if (cnt == TMO_LAST) begin
            bus_req <= 1'b0;
            m_err   <= bus_grant;
            m_rdata <= '1;
            state   <= DONE;
          end
        end
        DONE: begin
          m_ack <= '0;
          m_err <= '0;
          load  <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          // Keep ownership until the master drops its request, so a held req is not re-granted.
          if (!own_req) begin
            bus_grant <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
